// File: rtl/bus_gnrtr_n_rbtr_pkg.sv
// Shared definitions for the bus generator / arbiter.
// Holds the destination-ID width, the per-bus FSM state encoding and the
// default broadcast destination ID.
package bus_gnrtr_n_rbtr_pkg;

    // Width of the destination-ID field at the top of every packet
    localparam int unsigned ID_W = 8;

    // Destination ID that addresses every agent except the sender
    localparam logic [ID_W-1:0] BCAST_ID_DFLT = 8'hFF;

    // Per-bus sequencing: wait for a request, dequeue it, present it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } bus_state_e;

endpackage : bus_gnrtr_n_rbtr_pkg

// File: rtl/bus_gnrtr_n_rbtr_bus_arbiter_1.sv
// One shared bus: round-robin grant among pending agents, dequeue of the
// granted agent's head word, then delivery of that word to its destination
// (or to every other agent on broadcast).
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   pndng_i     - per-agent FIFO non-empty
//   d_pop_i     - per-agent FIFO head word (first-word-fall-through)
//   pop_o       - one-cycle dequeue strobe to the granted agent
//   push_o      - one-cycle write strobe into the destination agent(s)
//   d_push_o    - bus data, identical on every agent
module bus_arbiter_1
    import bus_gnrtr_n_rbtr_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID_DFLT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng_i,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop_i,
    output logic [drvrs-1:0]                 pop_o,
    output logic [drvrs-1:0]                 push_o,
    output logic [drvrs-1:0][pckg_sz-1:0]    d_push_o
);

    localparam int unsigned      PTR_W    = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(drvrs - 1);

    bus_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q,   ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [pckg_sz-1:0]  pkt_q,   pkt_d;
    logic [drvrs-1:0]    pop_q,   pop_d;
    logic [drvrs-1:0]    push_q,  push_d;

    logic                any_c;
    logic [PTR_W-1:0]    pick_c;
    logic [drvrs-1:0]    pick_oh_c;
    logic [pckg_sz-1:0]  head_c;
    logic [ID_W-1:0]     dest_c;
    logic [drvrs-1:0]    dec_c;

    // First pending agent at or after the pointer, wrapping mod drvrs
    always_comb begin : p_rr_pick
        int unsigned idx;
        idx    = 0;
        any_c  = 1'b0;
        pick_c = '0;
        for (int unsigned off = 0; off < drvrs; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= drvrs) begin
                idx = idx - drvrs;
            end
            if (!any_c && pndng_i[PTR_W'(idx)]) begin
                any_c  = 1'b1;
                pick_c = PTR_W'(idx);
            end
        end
    end

    always_comb begin : p_pick_oh
        pick_oh_c = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            pick_oh_c[i] = (PTR_W'(i) == pick_c);
        end
    end

    // Head word of the agent granted in the previous cycle
    assign head_c = d_pop_i[grant_q];
    assign dest_c = head_c[pckg_sz-1 -: ID_W];

    // Destination decode; out-of-range, non-broadcast IDs push nowhere
    always_comb begin : p_dest_dec
        dec_c = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (dest_c == broadcast) begin
                dec_c[i] = (PTR_W'(i) != grant_q);
            end else begin
                dec_c[i] = (dest_c == ID_W'(i));
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin : p_fsm_next
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        pkt_d   = pkt_q;
        pop_d   = '0;
        push_d  = '0;
        case (state_q)
            // pndng here is already post-dequeue, so a single-entry FIFO
            // is never popped twice
            ST_IDLE, ST_PUSH: begin
                if (any_c) begin
                    state_d = ST_POP;
                    grant_d = pick_c;
                    ptr_d   = (pick_c == LAST_IDX) ? '0 : pick_c + PTR_W'(1);
                    pop_d   = pick_oh_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d = ST_PUSH;
                pkt_d   = head_c;
                push_d  = dec_c;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            pkt_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pkt_q   <= pkt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
        end
    end

    assign pop_o    = pop_q;
    assign push_o   = push_q;
    // pkt_q keeps the last packet on the bus after push drops
    assign d_push_o = {drvrs{pkt_q}};

endmodule : bus_arbiter_1

// File: rtl/bus_gnrtr_n_rbtr.sv
// Bus generator and arbiter: `bits` independent shared buses, each serving
// `drvrs` FIFO-fronted agents with round-robin arbitration.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   pndng       - [bus][agent] FIFO non-empty
//   D_pop       - [bus][agent] FIFO head word
//   pop         - [bus][agent] dequeue strobe
//   push        - [bus][agent] write strobe
//   D_push      - [bus][agent] bus data, same on every agent of a bus
module bus_gnrtr_n_rbtr
    import bus_gnrtr_n_rbtr_pkg::*;
#(
    parameter int unsigned     bits      = 1,
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID_DFLT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    // One fully independent arbiter per bus
    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_arbiter_1 #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_bus (
            .clk      (clk),
            .reset    (reset),
            .pndng_i  (pndng[b]),
            .d_pop_i  (D_pop[b]),
            .pop_o    (pop[b]),
            .push_o   (push[b]),
            .d_push_o (D_push[b])
        );
    end

endmodule : bus_gnrtr_n_rbtr

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Self-checking bench for bus_gnrtr_n_rbtr (1 bus, 8 agents, 16-bit packets).
// Agent FIFOs are modelled in the bench; every observed pop queues the
// expected push vector and bus data, checked in the following cycle.
module tb_bus_gnrtr_n_rbtr;

    localparam int unsigned BITS  = 1;
    localparam int unsigned DRV   = 8;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic [BITS-1:0][DRV-1:0]         pndng;
    logic [BITS-1:0][DRV-1:0][PW-1:0] D_pop;
    logic [BITS-1:0][DRV-1:0]         pop;
    logic [BITS-1:0][DRV-1:0]         push;
    logic [BITS-1:0][DRV-1:0][PW-1:0] D_push;

    bus_gnrtr_n_rbtr #(
        .bits      (BITS),
        .drvrs     (DRV),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             agent;
        logic [PW-1:0]  pkt;
        logic [DRV-1:0] exp_push;
    } vec_t;

    typedef struct {
        logic [DRV-1:0] push;
        logic [PW-1:0]  data;
    } exp_t;

    logic [PW-1:0]  mem [DRV][DEPTH];
    int             ahead [DRV];
    int             atail [DRV];
    exp_t           sbq[$];
    int             grants[$];
    int             gcyc[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    logic [DRV-1:0] pop_prev, pop_s, push_s;
    logic [DRV-1:0][PW-1:0] dp_s;
    bit             exp_next;
    bit             tbl_mode;
    logic [DRV-1:0] tbl_push;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DRV-1:0] exp_push_f(input logic [PW-1:0] pkt, input int g);
        logic [7:0]     dest;
        logic [DRV-1:0] r;
        dest = pkt[PW-1 -: 8];
        r    = '0;
        if (dest == 8'hFF) begin
            r    = '1;
            r[g] = 1'b0;
        end else if (dest < DRV) begin
            r[dest[2:0]] = 1'b1;
        end
        return r;
    endfunction

    task automatic refresh();
        for (int i = 0; i < DRV; i++) begin
            pndng[0][i] = (atail[i] > ahead[i]);
            D_pop[0][i] = (atail[i] > ahead[i]) ? mem[i][ahead[i]] : 16'h0000;
        end
    endtask

    task automatic load(input int a, input logic [PW-1:0] p);
        mem[a][atail[a]] = p;
        atail[a]++;
    endtask

    task automatic clear_agents();
        for (int i = 0; i < DRV; i++) begin
            ahead[i] = 0;
            atail[i] = 0;
        end
        refresh();
    endtask

    // One clock: FIFOs dequeue after the edge, outputs sampled on negedge
    task automatic tick();
        exp_t e;
        int   g;
        @(posedge clk);
        #1;
        for (int i = 0; i < DRV; i++) begin
            if (pop_prev[i] && ahead[i] < atail[i]) ahead[i]++;
        end
        refresh();
        @(negedge clk);
        cyc++;
        pop_s    = pop[0];
        push_s   = push[0];
        dp_s     = D_push[0];
        pop_prev = pop_s;
        if (exp_next) begin
            exp_next = 1'b0;
            e = sbq.pop_front();
            chk("sb_push", push_s, e.push);
            chk("sb_dpush", dp_s, {DRV{e.data}});
            chk("sb_no_pop_in_push", pop_s, 0);
        end
        if (pop_s != '0) begin
            chk("pop_onehot", $onehot(pop_s), 1);
            g = 0;
            for (int i = DRV - 1; i >= 0; i--) begin
                if (pop_s[i]) g = i;
            end
            e.data = mem[g][ahead[g]];
            e.push = tbl_mode ? tbl_push : exp_push_f(e.data, g);
            sbq.push_back(e);
            exp_next = 1'b1;
            grants.push_back(g);
            gcyc.push_back(cyc);
        end
    endtask

    task automatic wait_grant(input int maxc, output int g, output bit ok);
        int n0;
        int k;
        n0 = grants.size();
        k  = 0;
        while (grants.size() == n0 && k < maxc) begin
            tick();
            k++;
        end
        ok = (grants.size() != n0);
        g  = ok ? grants[grants.size()-1] : -1;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: got no pop within %0d cycles, required one", maxc);
        end
    endtask

    vec_t          vt [10];
    logic [PW-1:0] rpkt [DRV];
    int            rr_exp [9];

    initial begin
        int g;
        bit ok;
        int k;

        vt[0] = '{2, 16'h05AB, 8'b0010_0000};
        vt[1] = '{3, 16'hFF12, 8'b1111_0111};
        vt[2] = '{0, 16'h2A00, 8'h00};
        vt[3] = '{5, 16'h05CC, 8'h20};
        vt[4] = '{7, 16'h0055, 8'h01};
        vt[5] = '{0, 16'hFF00, 8'hFE};
        vt[6] = '{7, 16'hFF34, 8'h7F};
        vt[7] = '{1, 16'h0812, 8'h00};
        vt[8] = '{6, 16'h0799, 8'h80};
        vt[9] = '{4, 16'hFE01, 8'h00};

        rpkt   = '{16'h0100, 16'hFF11, 16'h0222, 16'h0933,
                   16'h0744, 16'h0055, 16'hFF66, 16'h0877};
        rr_exp = '{1, 4, 6, 1, 4, 6, 1, 4, 6};

        reset    = 1'b1;
        pop_prev = '0;
        exp_next = 1'b0;
        tbl_mode = 1'b0;
        tbl_push = '0;
        clear_agents();

        // Reset held with every agent pending
        for (int i = 0; i < DRV; i++) load(i, rpkt[i]);
        refresh();
        repeat (3) begin
            tick();
            chk("rst_pop", pop_s, 0);
            chk("rst_push", push_s, 0);
            chk("rst_dpush", dp_s, 0);
        end
        reset = 1'b0;
        wait_grant(4, g, ok);
        if (ok) chk("first_pop_agent", g, 0);
        repeat (20) tick();
        chk("rst_drain_count", grants.size(), DRV);
        for (int i = 0; i < grants.size() && i < DRV; i++) chk("rst_rr_order", grants[i], i);

        // Single-packet vectors
        tbl_mode = 1'b1;
        foreach (vt[v]) begin
            grants.delete();
            clear_agents();
            tbl_push = vt[v].exp_push;
            load(vt[v].agent, vt[v].pkt);
            refresh();
            wait_grant(6, g, ok);
            if (ok) begin
                chk("tbl_grant", g, vt[v].agent);
                tick();
                tick();
                chk("tbl_push_drop", push_s, 0);
                chk("tbl_dpush_hold", dp_s, {DRV{vt[v].pkt}});
            end
        end
        tbl_mode = 1'b0;

        // Round-robin under continuous load from agents 1, 4, 6
        reset = 1'b1;
        grants.delete();
        gcyc.delete();
        clear_agents();
        for (int j = 0; j < 3; j++) begin
            load(1, 16'h0400 | 16'(j));
            load(4, 16'hFF40 | 16'(j));
            load(6, 16'h0960 | 16'(j));
        end
        refresh();
        tick();
        reset = 1'b0;
        k = 0;
        while (grants.size() < 9 && k < 40) begin
            tick();
            k++;
        end
        chk("rr_count", grants.size(), 9);
        for (int i = 0; i < grants.size() && i < 9; i++) chk("rr_order", grants[i], rr_exp[i]);
        for (int i = 1; i < gcyc.size(); i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 2);
        repeat (4) tick();
        chk("rr_no_extra_pop", grants.size(), 9);

        // Reset landing on the PUSH cycle of 16'h0333
        grants.delete();
        clear_agents();
        load(5, 16'h0333);
        refresh();
        wait_grant(20, g, ok);
        if (ok) begin
            chk("mr_grant", g, 5);
            tick();
            chk("mr_in_push", push_s, 8'h08);
            load(0, 16'h0211);
            load(6, 16'h0166);
            reset = 1'b1;
            refresh();
            tick();
            chk("mr_pop", pop_s, 0);
            chk("mr_push", push_s, 0);
            chk("mr_dpush", dp_s, 0);
            reset = 1'b0;
            wait_grant(4, g, ok);
            if (ok) chk("mr_next_grant", g, 0);
            wait_grant(6, g, ok);
            if (ok) chk("mr_second_grant", g, 6);
            repeat (3) tick();
        end
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_gnrtr_n_rbtr
